// File: rtl/bit_match_pkg.sv
// -----------------------------------------------------------------------------
// bit_match_pkg
// Shared definitions for the sequential bit-pair match engine:
//   - FSM state type and encoding (IDLE / SCAN / DONE)
//   - calc_chunks : number of scan cycles needed for WIDTH bits at LANES per cycle
//   - clog2_min1  : $clog2 clamped to a minimum of 1 bit (for index fields)
// -----------------------------------------------------------------------------
package bit_match_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SCAN = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic int calc_chunks(input int width, input int lanes);
    return (width + lanes - 1) / lanes;
  endfunction

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/bit_match_lane_slice.sv
// -----------------------------------------------------------------------------
// bit_match_lane_slice
// Combinational evaluation of one LANES-wide slice of the two operands.
// Only lanes with i_mask=1 take part; masked lanes are neither counted, nor
// set the any-flag, nor clear the all-flag.
//
// Optional feature macro: BIT_MATCH_FIRST_DIFF_EN (adds o_diff / o_diff_idx).
//
// Ports:
//   i_x, i_y    in  [LANES-1:0]          operand slices
//   i_mask      in  [LANES-1:0]          1 = lane holds a real operand bit
//   o_pop       out [$clog2(LANES+1)-1:0] number of valid equal lanes
//   o_any       out                      at least one valid lane equal
//   o_all       out                      every valid lane equal
//   o_diff      out                      (feature) some valid lane differs
//   o_diff_idx  out                      (feature) lowest differing lane
// -----------------------------------------------------------------------------
module bit_match_lane_slice
  import bit_match_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic [LANES-1:0]               i_x,
  input  logic [LANES-1:0]               i_y,
  input  logic [LANES-1:0]               i_mask,
  output logic [$clog2(LANES+1)-1:0]     o_pop,
  output logic                           o_any,
  output logic                           o_all
`ifdef BIT_MATCH_FIRST_DIFF_EN
  ,
  output logic                           o_diff,
  output logic [clog2_min1(LANES)-1:0]   o_diff_idx
`endif
);

  localparam int PC_W = $clog2(LANES + 1);

  logic [LANES-1:0] w_eq;
  logic [LANES-1:0] w_diff;

  assign w_eq   = ~(i_x ^ i_y) & i_mask;
  assign w_diff =  (i_x ^ i_y) & i_mask;

  // Masked lanes are forced to "equal" for the AND so they cannot clear o_all.
  assign o_any = |w_eq;
  assign o_all = &(w_eq | ~i_mask);

  always_comb begin
    // NOTE: every output of a combinational block gets a default before the
    // loop; otherwise a path that skips the assignment infers a latch.
    o_pop = '0;
    for (int j = 0; j < LANES; j++) begin
      o_pop = o_pop + PC_W'(w_eq[j]);
    end
  end

`ifdef BIT_MATCH_FIRST_DIFF_EN
  localparam int LI_W = clog2_min1(LANES);

  assign o_diff = |w_diff;

  // Walk from the top lane down so the lowest differing lane wins.
  always_comb begin
    o_diff_idx = '0;
    for (int j = LANES - 1; j >= 0; j--) begin
      if (w_diff[j]) o_diff_idx = LI_W'(j);
    end
  end
`endif

endmodule

// File: rtl/param_bit_match_seq.sv
// -----------------------------------------------------------------------------
// param_bit_match_seq
// Multi-cycle bit-pair compare engine. On an accepted start the operands are
// captured; LANES bit-pairs are then scanned per cycle for CHUNKS cycles, and
// any-equal / all-equal / equal-count are published on entry to DONE, where
// done pulses for one cycle. Results hold until the next DONE.
//
// Optional feature macro: BIT_MATCH_FIRST_DIFF_EN (adds first_diff and
// first_diff_idx, the lowest bit position where x and y differ).
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   start          in   request compare; honoured only in IDLE or DONE
//   x, y           in   [WIDTH-1:0] operands, sampled on the accepted start
//   busy           out  high while scanning
//   done           out  one-cycle pulse, results valid
//   any_eq         out  some pair equal
//   all_eq         out  every pair equal
//   eq_count       out  [CNT_W-1:0] number of equal pairs
//   first_diff     out  (feature) some pair differs
//   first_diff_idx out  (feature) lowest differing bit index
// -----------------------------------------------------------------------------
module param_bit_match_seq
  import bit_match_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int LANES  = 2,
  localparam int CNT_W  = $clog2(WIDTH + 1),
  localparam int CHUNKS = calc_chunks(WIDTH, LANES),
  localparam int FD_W   = clog2_min1(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             any_eq,
  output logic             all_eq,
  output logic [CNT_W-1:0] eq_count
`ifdef BIT_MATCH_FIRST_DIFF_EN
  ,
  output logic             first_diff,
  output logic [FD_W-1:0]  first_diff_idx
`endif
);

  localparam int PAD_W = CHUNKS * LANES;
  localparam int CI_W  = clog2_min1(CHUNKS);
  localparam int PC_W  = $clog2(LANES + 1);
  localparam logic [CI_W-1:0] LAST_IDX = CI_W'(CHUNKS - 1);

  // State, captured operands, scan index
  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [CI_W-1:0]  r_idx;

  // Running accumulators and published results
  logic             r_any_acc, r_all_acc;
  logic [CNT_W-1:0] r_cnt_acc;
  logic             r_any, r_all;
  logic [CNT_W-1:0] r_cnt;

  logic [PAD_W-1:0] w_x_pad, w_y_pad;
  logic [LANES-1:0] w_x_s, w_y_s, w_mask;
  logic [PC_W-1:0]  w_pop;
  logic             w_s_any, w_s_all;
  logic             w_accept, w_last;
  logic             w_any_nxt, w_all_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Operands are zero-extended to a whole number of chunks; the mask, not the
  // pad value, is what keeps the pad bits out of the result.
  always_comb begin
    w_x_pad = '0;
    w_y_pad = '0;
    w_x_pad[WIDTH-1:0] = r_x;
    w_y_pad[WIDTH-1:0] = r_y;
    w_x_s = w_x_pad[int'(r_idx)*LANES +: LANES];
    w_y_s = w_y_pad[int'(r_idx)*LANES +: LANES];
    w_mask = '0;
    for (int j = 0; j < LANES; j++) begin
      w_mask[j] = (int'(r_idx) * LANES + j) < WIDTH;
    end
  end

`ifdef BIT_MATCH_FIRST_DIFF_EN
  localparam int LI_W = clog2_min1(LANES);

  logic             r_fd_acc, r_fd;
  logic [FD_W-1:0]  r_fd_idx_acc, r_fd_idx;
  logic             w_s_diff;
  logic [LI_W-1:0]  w_s_diff_idx;
  logic             w_fd_nxt;
  logic [FD_W-1:0]  w_fd_idx_nxt;
`endif

  bit_match_lane_slice #(
    .LANES (LANES)
  ) u_slice (
    .i_x        (w_x_s),
    .i_y        (w_y_s),
    .i_mask     (w_mask),
    .o_pop      (w_pop),
    .o_any      (w_s_any),
    .o_all      (w_s_all)
`ifdef BIT_MATCH_FIRST_DIFF_EN
    ,
    .o_diff     (w_s_diff),
    .o_diff_idx (w_s_diff_idx)
`endif
  );

  assign w_accept  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last    = (r_idx == LAST_IDX);
  assign w_any_nxt = r_any_acc | w_s_any;
  assign w_all_nxt = r_all_acc & w_s_all;
  assign w_cnt_nxt = r_cnt_acc + CNT_W'(w_pop);

`ifdef BIT_MATCH_FIRST_DIFF_EN
  // Chunks are scanned low to high, so the first chunk that reports a
  // difference holds the lowest differing bit; later chunks must not overwrite it.
  assign w_fd_nxt     = r_fd_acc | w_s_diff;
  assign w_fd_idx_nxt = r_fd_acc ? r_fd_idx_acc :
                        (w_s_diff ? FD_W'(int'(r_idx) * LANES + int'(w_s_diff_idx)) : '0);
`endif

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_idx     <= '0;
      r_any_acc <= 1'b0;
      r_all_acc <= 1'b0;
      r_cnt_acc <= '0;
      r_any     <= 1'b0;
      r_all     <= 1'b0;
      r_cnt     <= '0;
`ifdef BIT_MATCH_FIRST_DIFF_EN
      r_fd_acc     <= 1'b0;
      r_fd_idx_acc <= '0;
      r_fd         <= 1'b0;
      r_fd_idx     <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_x       <= x;
            r_y       <= y;
            r_idx     <= '0;
            r_any_acc <= 1'b0;
            r_all_acc <= 1'b1;
            r_cnt_acc <= '0;
`ifdef BIT_MATCH_FIRST_DIFF_EN
            r_fd_acc     <= 1'b0;
            r_fd_idx_acc <= '0;
`endif
            r_state   <= ST_SCAN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          r_any_acc <= w_any_nxt;
          r_all_acc <= w_all_nxt;
          r_cnt_acc <= w_cnt_nxt;
`ifdef BIT_MATCH_FIRST_DIFF_EN
          r_fd_acc     <= w_fd_nxt;
          r_fd_idx_acc <= w_fd_idx_nxt;
`endif
          if (w_last) begin
            // Publish straight from the final accumulate so results are
            // visible in the DONE cycle itself.
            r_any   <= w_any_nxt;
            r_all   <= w_all_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef BIT_MATCH_FIRST_DIFF_EN
            r_fd     <= w_fd_nxt;
            r_fd_idx <= w_fd_idx_nxt;
`endif
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (r_state == ST_SCAN);
  assign done     = (r_state == ST_DONE);
  assign any_eq   = r_any;
  assign all_eq   = r_all;
  assign eq_count = r_cnt;
`ifdef BIT_MATCH_FIRST_DIFF_EN
  assign first_diff     = r_fd;
  assign first_diff_idx = r_fd_idx;
`endif

endmodule

// File: tb/tb_param_bit_match_seq.sv
// -----------------------------------------------------------------------------
// tb_param_bit_match_seq
// Two instances: WIDTH=8/LANES=2 (CHUNKS=4) and WIDTH=5/LANES=2 (CHUNKS=3,
// one padded lane). A model process per instance pushes the expected result
// into a queue on each start the protocol accepts; a monitor per instance
// pops and compares when done is due, and checks busy/done/held results
// every cycle. Optional outputs are checked when BIT_MATCH_FIRST_DIFF_EN is set.
// -----------------------------------------------------------------------------
module tb_param_bit_match_seq;

  typedef struct {
    int done_at;
    bit any;
    bit all;
    int cnt;
    bit fd;
    int fdi;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start [2];
  logic [7:0] xv    [2];
  logic [7:0] yv    [2];

  logic       busy_o [2];
  logic       done_o [2];
  logic       any_o  [2];
  logic       all_o  [2];
  logic [7:0] cnt_o  [2];
  logic       fd_o   [2];
  logic [7:0] fdi_o  [2];

  logic [3:0] cnt8;
  logic [2:0] cnt5;
  logic       b8, b5, d8, d5, a8, a5, l8, l5;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   last_rst [2];

  param_bit_match_seq #(.WIDTH(8), .LANES(2)) u_dut8 (
    .clk      (clk),
    .reset    (reset),
    .start    (start[0]),
    .x        (xv[0]),
    .y        (yv[0]),
    .busy     (b8),
    .done     (d8),
    .any_eq   (a8),
    .all_eq   (l8),
    .eq_count (cnt8)
`ifdef BIT_MATCH_FIRST_DIFF_EN
    ,
    .first_diff     (fd_o[0]),
    .first_diff_idx (fdi_o[0][2:0])
`endif
  );

  param_bit_match_seq #(.WIDTH(5), .LANES(2)) u_dut5 (
    .clk      (clk),
    .reset    (reset),
    .start    (start[1]),
    .x        (xv[1][4:0]),
    .y        (yv[1][4:0]),
    .busy     (b5),
    .done     (d5),
    .any_eq   (a5),
    .all_eq   (l5),
    .eq_count (cnt5)
`ifdef BIT_MATCH_FIRST_DIFF_EN
    ,
    .first_diff     (fd_o[1]),
    .first_diff_idx (fdi_o[1][2:0])
`endif
  );

  assign busy_o[0] = b8;
  assign busy_o[1] = b5;
  assign done_o[0] = d8;
  assign done_o[1] = d5;
  assign any_o[0]  = a8;
  assign any_o[1]  = a5;
  assign all_o[0]  = l8;
  assign all_o[1]  = l5;
  assign cnt_o[0]  = {4'b0, cnt8};
  assign cnt_o[1]  = {5'b0, cnt5};
`ifdef BIT_MATCH_FIRST_DIFF_EN
  assign fdi_o[0][7:3] = '0;
  assign fdi_o[1][7:3] = '0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference: counts directly from the operand bits, no notion of chunks.
  function automatic exp_t ref_result(input logic [7:0] a, input logic [7:0] b, input int w);
    exp_t r;
    logic [7:0] m;
    logic [7:0] eqb;
    m      = 8'((1 << w) - 1);
    eqb    = ~(a ^ b) & m;
    r.done_at = 0;
    r.cnt  = $countones(eqb);
    r.any  = (r.cnt != 0);
    r.all  = (r.cnt == w);
    r.fd   = (r.cnt != w);
    r.fdi  = 0;
    for (int i = w - 1; i >= 0; i--) begin
      if (a[i] != b[i]) r.fdi = i;
    end
    return r;
  endfunction

  function automatic int qsize(input int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int id);
    return (id == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpush(input int id, input exp_t e);
    if (id == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic qpop(input int id);
    if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endtask

  task automatic qflush(input int id);
    if (id == 0) q0.delete(); else q1.delete();
  endtask

  // Protocol model: a start is accepted on edge e only if the previous
  // compare has already reached DONE (edge >= free). Result due CHUNKS edges later.
  task automatic model_proc(input int id);
    int e    = 0;
    int free = 0;
    int w    = (id == 0) ? 8 : 5;
    int ch   = (id == 0) ? 4 : 3;
    exp_t r;
    forever begin
      @(posedge clk);
      e++;
      if (reset) begin
        qflush(id);
        last_rst[id] = e;
        free = e + 1;
      end else if (start[id] && e >= free) begin
        r = ref_result(xv[id], yv[id], w);
        r.done_at = e + ch;
        qpush(id, r);
        free = e + ch + 1;
      end
    end
  endtask

  task automatic monitor_proc(input int id);
    int   k = 0;
    bit   ed, eb;
    exp_t held;
    string p;
    p = (id == 0) ? "w8" : "w5";
    held = '{0, 1'b0, 1'b0, 0, 1'b0, 0};
    forever begin
      @(negedge clk);
      k++;
      if (last_rst[id] == k) held = '{0, 1'b0, 1'b0, 0, 1'b0, 0};
      ed = (qsize(id) > 0) && (qfront(id).done_at == k);
      eb = (qsize(id) > 0) && (k < qfront(id).done_at);
      check({p, " busy"}, 32'(busy_o[id]), 32'(eb));
      check({p, " done"}, 32'(done_o[id]), 32'(ed));
      if (done_o[id] && ed) begin
        held = qfront(id);
        qpop(id);
      end else if (ed) begin
        qpop(id);
      end
      check({p, " any_eq"},   32'(any_o[id]), 32'(held.any));
      check({p, " all_eq"},   32'(all_o[id]), 32'(held.all));
      check({p, " eq_count"}, 32'(cnt_o[id]), 32'(held.cnt));
`ifdef BIT_MATCH_FIRST_DIFF_EN
      check({p, " first_diff"},     32'(fd_o[id]),  32'(held.fd));
      check({p, " first_diff_idx"}, 32'(fdi_o[id]), 32'(held.fdi));
`endif
    end
  endtask

  initial begin
    last_rst[0] = -1;
    last_rst[1] = -1;
    fork
      model_proc(0);
      model_proc(1);
      monitor_proc(0);
      monitor_proc(1);
    join_none
  end

  task automatic one_shot(input logic [7:0] a0, input logic [7:0] b0,
                          input logic [7:0] a1, input logic [7:0] b1);
    @(negedge clk);
    start[0] = 1'b1; xv[0] = a0; yv[0] = b0;
    start[1] = 1'b1; xv[1] = a1; yv[1] = b1;
    @(negedge clk);
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      xv[i]    = '0;
      yv[i]    = '0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed operand pairs, including the padded-lane case on the 5-bit unit.
    one_shot(8'hA5, 8'hA5, 8'h1F, 8'h1F);
    one_shot(8'hFF, 8'h00, 8'h00, 8'h1F);
    one_shot(8'h0F, 8'h0E, 8'h15, 8'h0A);
    one_shot(8'h80, 8'h00, 8'h1E, 8'h1F);
    one_shot(8'h00, 8'h00, 8'h10, 8'h00);

    // start held high with operands changing every cycle: back-to-back compares.
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        start[i] = 1'b1;
        xv[i]    = 8'($urandom);
        yv[i]    = 8'($urandom);
      end
    end
    @(negedge clk);
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (6) @(negedge clk);

    // Reset on the second SCAN cycle, then a normal compare.
    start[0] = 1'b1; xv[0] = 8'h3C; yv[0] = 8'h3C;
    start[1] = 1'b1; xv[1] = 8'h0A; yv[1] = 8'h0A;
    @(negedge clk);
    start[0] = 1'b0;
    start[1] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    one_shot(8'h5A, 8'h5B, 8'h03, 8'h01);

    // Reset and start together: reset must win.
    reset = 1'b1;
    start[0] = 1'b1;
    start[1] = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (3) @(negedge clk);

    // Random traffic; operands sometimes forced equal to exercise all_eq.
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        start[i] = ($urandom_range(0, 2) == 0);
        xv[i]    = 8'($urandom);
        yv[i]    = ($urandom_range(0, 3) == 0) ? xv[i] : 8'($urandom);
      end
    end
    @(negedge clk);
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (8) @(negedge clk);

    check("w8 drain", 32'(q0.size()), 32'd0);
    check("w5 drain", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
